// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// State encoding, default operand widths and step-counter sizing.
package seq_divider_pkg;

  localparam int DIVIDEND_W_DEF = 4;
  localparam int DIVISOR_W_DEF  = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } div_state_t;

  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(DIVIDEND_W_DEF);

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0]   p;
  logic [DIVISOR_W-1:0] diff;

  // diff only matters when p >= divisor, so the result fits DIVISOR_W bits
  always_comb begin
    p       = {rem_in, bit_in};
    diff    = p[DIVISOR_W-1:0] - divisor;
    q_bit   = (p >= {1'b0, divisor});
    rem_out = q_bit ? diff : p[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider behind a start/done handshake.
// One quotient bit per clock; divide-by-zero resolves in a single edge.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);

  div_state_t state, state_nxt;

  logic [DIVIDEND_W-1:0] dvd_sh;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  prem;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W-1:0]  rem_nxt;
  logic                  q_bit;
  logic                  accept;
  logic                  last;

  div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .rem_in (prem),
    .bit_in (dvd_sh[DIVIDEND_W-1]),
    .divisor(dvs),
    .rem_out(rem_nxt),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (cnt == '0);
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // dvd_sh shifts dividend bits out the top and quotient bits in the bottom
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_sh      <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd_sh      <= dividend;
      dvs         <= divisor;
      prem        <= '0;
      cnt         <= CNT_W'(DIVIDEND_W - 1);
      div_by_zero <= 1'b0;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= '0;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      dvd_sh <= {dvd_sh[DIVIDEND_W-2:0], q_bit};
      prem   <= rem_nxt;
      cnt    <= cnt - 1'b1;
      if (last) begin
        quotient  <= {dvd_sh[DIVIDEND_W-2:0], q_bit};
        remainder <= rem_nxt;
      end
    end
  end

endmodule
